// File: rtl/adc_cal_pkg.sv
// adc_cal_pkg: FSM state encoding and default calibration constants
package adc_cal_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, EVAL, CENTER, NEXT_CH, DONE} cal_state_t;
    localparam logic [15:0] CAL_TRAIN_PAT = 16'hA5C3;
    localparam int CAL_DEF_TAP = 12;
    localparam int CAL_MIN_WIN = 4;
endpackage

// File: rtl/adc_nch_tap_cal_if.sv
// adc_nch_tap_cal_if: calibration control, ADC data and delay-line tap bus
interface adc_nch_tap_cal_if #(
    parameter int CH_NUM = 4,
    parameter int DATA_W = 16,
    parameter int TAP_W  = 5
);
    logic                       CAL_START;
    logic [CH_NUM*DATA_W-1:0]   CH_DATA_IN;
    logic [CH_NUM*DATA_W-1:0]   CH_DATA_OUT;
    logic [CH_NUM*TAP_W-1:0]    DLY_TAP_OUT;
    logic [CH_NUM-1:0]          DLY_LOAD;
    logic [CH_NUM-1:0]          CAL_FAIL;
    logic                       DATA_VALID;
    logic                       CAL_BUSY;
    logic                       CAL_DONE;
    modport master (
        output CAL_START, CH_DATA_IN,
        input  CH_DATA_OUT, DLY_TAP_OUT, DLY_LOAD, CAL_FAIL, DATA_VALID, CAL_BUSY, CAL_DONE
    );
    modport slave (
        input  CAL_START, CH_DATA_IN,
        output CH_DATA_OUT, DLY_TAP_OUT, DLY_LOAD, CAL_FAIL, DATA_VALID, CAL_BUSY, CAL_DONE
    );
endinterface

// File: rtl/adc_win_tracker.sv
// adc_win_tracker: tracks the current passing-tap run and the longest run seen
module adc_win_tracker #(
    parameter int TAP_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             upd,
    input  logic             pass,
    input  logic             close,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W:0]   best_len
);
    logic [TAP_W-1:0] cur_start, bst_start;
    logic [TAP_W:0]   cur_len, bst_len;
    logic             take;
    // an open run only displaces the stored best when strictly longer, so ties keep the earlier run
    assign take       = cur_len > bst_len;
    assign best_start = take ? cur_start : bst_start;
    assign best_len   = take ? cur_len : bst_len;
    // run bookkeeping: extend on pass, commit and restart on fail or close
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_start <= '0;
            cur_len   <= '0;
            bst_start <= '0;
            bst_len   <= '0;
        end else if (clear) begin
            cur_start <= '0;
            cur_len   <= '0;
            bst_start <= '0;
            bst_len   <= '0;
        end else if (close || (upd && !pass)) begin
            bst_start <= best_start;
            bst_len   <= best_len;
            cur_len   <= '0;
        end else if (upd) begin
            if (cur_len == '0) cur_start <= tap;
            cur_len <= cur_len + 1'b1;
        end
    end
endmodule

// File: rtl/adc_nch_tap_cal.sv
// adc_nch_tap_cal: per-channel IDELAY tap sweep against a training word, centres each channel in its widest eye
module adc_nch_tap_cal import adc_cal_pkg::*; #(
    parameter int                CH_NUM     = 4,
    parameter int                DATA_W     = 16,
    parameter int                TAP_W      = 5,
    parameter logic [DATA_W-1:0] TRAIN_PAT  = DATA_W'(CAL_TRAIN_PAT),
    parameter int                SETTLE_CYC = 16,
    parameter int                CHECK_CYC  = 64,
    parameter int                MIN_WIN    = CAL_MIN_WIN,
    parameter int                DEF_TAP    = CAL_DEF_TAP
) (
    input logic             ADCLK_100M,
    input logic             IO_RST_N,
    adc_nch_tap_cal_if.slave bus
);
    localparam int CH_W  = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
    localparam int CNT_W = $clog2((SETTLE_CYC > CHECK_CYC ? SETTLE_CYC : CHECK_CYC) + 1);

    cal_state_t                      state, state_n;
    logic [CH_W-1:0]                 ch;
    logic [TAP_W-1:0]                tap, best_start, ctr;
    logic [TAP_W:0]                  best_len, ctr_w;
    logic [CNT_W-1:0]                cnt;
    logic                            ok, start, busy, done, good, tap_max, ch_last;
    logic                            trk_clear, trk_upd, trk_close;
    logic [CH_NUM-1:0][TAP_W-1:0]    taps;
    logic [CH_NUM-1:0]               load, fail;
    logic [CH_NUM*DATA_W-1:0]        data_q;
    logic [DATA_W-1:0]               word;

    assign start   = bus.CAL_START;
    assign tap_max = &tap;
    assign ch_last = ch == CH_W'(CH_NUM - 1);
    assign word    = bus.CH_DATA_IN[int'(ch)*DATA_W +: DATA_W];
    assign good    = best_len >= (TAP_W + 1)'(MIN_WIN);
    assign ctr_w   = {1'b0, best_start} + (best_len >> 1);
    assign ctr     = ctr_w[TAP_W] ? '1 : ctr_w[TAP_W-1:0];

    adc_win_tracker #(.TAP_W(TAP_W)) u_trk (
        .clk        (ADCLK_100M),
        .rst_n      (IO_RST_N),
        .clear      (trk_clear),
        .upd        (trk_upd),
        .pass       (ok),
        .close      (trk_close),
        .tap        (tap),
        .best_start (best_start),
        .best_len   (best_len)
    );

    // state register; reset aborts any sweep in progress
    always_ff @(posedge ADCLK_100M or negedge IO_RST_N) begin
        if (!IO_RST_N) state <= IDLE;
        else           state <= state_n;
    end

    // sweep sequencing: load, settle, check, evaluate each tap, then centre and move to next channel
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = start ? LOAD : state;
            LOAD:       state_n = SETTLE;
            SETTLE:     state_n = cnt == CNT_W'(SETTLE_CYC - 1) ? CHECK : SETTLE;
            CHECK:      state_n = cnt == CNT_W'(CHECK_CYC - 1) ? EVAL : CHECK;
            EVAL:       state_n = tap_max ? CENTER : LOAD;
            CENTER:     state_n = NEXT_CH;
            NEXT_CH:    state_n = ch_last ? DONE : LOAD;
            default:    state_n = IDLE;
        endcase
    end

    // status and tracker control decoded from state
    always_comb begin
        busy      = !(state == IDLE || state == DONE);
        done      = state == DONE;
        trk_clear = (!busy && start) || state == NEXT_CH;
        trk_upd   = state == EVAL;
        trk_close = state == CENTER;
    end

    // datapath: dwell counter, pattern match, tap registers with their load strobes, fail flags, data pipe
    always_ff @(posedge ADCLK_100M or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            ch     <= '0;
            tap    <= '0;
            cnt    <= '0;
            ok     <= 1'b0;
            taps   <= {CH_NUM{TAP_W'(DEF_TAP)}};
            load   <= '0;
            fail   <= '0;
            data_q <= '0;
        end else begin
            data_q <= bus.CH_DATA_IN;
            load   <= '0;
            cnt    <= (state_n == state && (state == SETTLE || state == CHECK)) ? cnt + 1'b1 : '0;
            if (!busy && start) begin
                ch   <= '0;
                tap  <= '0;
                fail <= '0;
            end
            if (state == LOAD) begin
                taps[ch] <= tap;
                load[ch] <= 1'b1;
                ok       <= 1'b1;
            end
            if (state == CHECK) ok <= ok && word == TRAIN_PAT;
            if (state == EVAL && !tap_max) tap <= tap + 1'b1;
            if (state == CENTER) begin
                taps[ch] <= good ? ctr : TAP_W'(DEF_TAP);
                load[ch] <= 1'b1;
                fail[ch] <= fail[ch] | !good;
            end
            if (state == NEXT_CH) begin
                tap <= '0;
                if (!ch_last) ch <= ch + 1'b1;
            end
        end
    end

    assign bus.DLY_TAP_OUT = taps;
    assign bus.DLY_LOAD    = load;
    assign bus.CH_DATA_OUT = data_q;
    assign bus.CAL_FAIL    = fail;
    assign bus.CAL_BUSY    = busy;
    assign bus.CAL_DONE    = done;
    assign bus.DATA_VALID  = done && !(|fail);
endmodule

// File: tb/tb_adc_nch_tap_cal.sv
// tb_adc_nch_tap_cal: directed tap-sweep scenarios against a per-channel delay-line eye model
module tb_adc_nch_tap_cal;
    localparam int CH = 8;
    localparam int DW = 16;
    localparam int TW = 5;
    localparam int SET = 2;
    localparam int CHK = 4;
    localparam logic [15:0] PAT = 16'hA5C3;
    localparam int CAL_CYC = 2064;
    localparam int LOADS_PER_CAL = 264;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw = 1'b1;
    logic [CH*DW-1:0] raw_data = '0;
    logic [31:0] mask [CH];
    int total = 0;
    int bad = 0;
    int loads = 0;

    adc_nch_tap_cal_if #(.CH_NUM(CH), .DATA_W(DW), .TAP_W(TW)) bus ();

    adc_nch_tap_cal #(
        .CH_NUM(CH), .DATA_W(DW), .TAP_W(TW), .TRAIN_PAT(PAT),
        .SETTLE_CYC(SET), .CHECK_CYC(CHK), .MIN_WIN(4), .DEF_TAP(12)
    ) dut (
        .ADCLK_100M (clk),
        .IO_RST_N   (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) loads <= loads + $countones(bus.DLY_LOAD);

    // eye model: each channel sees the training word only at taps set in its mask
    always_comb begin
        bus.CH_DATA_IN = raw_data;
        if (!raw)
            for (int k = 0; k < CH; k++)
                bus.CH_DATA_IN[k*DW +: DW] = mask[k][bus.DLY_TAP_OUT[k*TW +: TW]] ? PAT : ~PAT;
    end

    function automatic logic [31:0] rng(input int lo, input int hi);
        rng = '0;
        for (int i = lo; i <= hi; i++) rng[i] = 1'b1;
    endfunction

    task automatic start_cal();
        bus.CAL_START = 1'b1;
        @(posedge clk);
        #1;
        bus.CAL_START = 1'b0;
    endtask

    task automatic wait_done(input int extra_at, output int n);
        n = 0;
        while (!bus.CAL_DONE && n < 3 * CAL_CYC) begin
            @(posedge clk);
            #1;
            n++;
            bus.CAL_START = (n == extra_at);
        end
        bus.CAL_START = 1'b0;
    endtask

    task automatic test_reset();
        raw = 1'b1;
        raw_data = {CH{16'h1234}};
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.DLY_TAP_OUT !== {CH{5'd12}}) begin bad++; $display("FAIL reset_taps got=%h want=%h", bus.DLY_TAP_OUT, {CH{5'd12}}); end
        total++; if (bus.DLY_LOAD !== 8'h00) begin bad++; $display("FAIL reset_load got=%h want=00", bus.DLY_LOAD); end
        total++; if (bus.CH_DATA_OUT !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.CH_DATA_OUT); end
        total++; if ({bus.DATA_VALID, bus.CAL_BUSY, bus.CAL_DONE} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {bus.DATA_VALID, bus.CAL_BUSY, bus.CAL_DONE}); end
        total++; if (bus.CAL_FAIL !== 8'h00) begin bad++; $display("FAIL reset_fail got=%h want=00", bus.CAL_FAIL); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.CAL_BUSY !== 1'b0 || bus.DLY_LOAD !== 8'h00) begin bad++; $display("FAIL idle_after_reset busy=%b load=%h want busy=0 load=00", bus.CAL_BUSY, bus.DLY_LOAD); end
    endtask

    task automatic test_data_pipe();
        logic [CH*DW-1:0] prev;
        raw = 1'b1;
        prev = {$urandom, $urandom, $urandom, $urandom};
        raw_data = prev;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            total++; if (bus.CH_DATA_OUT !== prev) begin bad++; $display("FAIL data_pipe[%0d] got=%h want=%h", i, bus.CH_DATA_OUT, prev); end
            prev = {$urandom, $urandom, $urandom, $urandom};
            raw_data = prev;
        end
    endtask

    task automatic test_cal_mixed();
        int n;
        int l0;
        raw = 1'b0;
        mask[0] = rng(8, 15);
        mask[1] = rng(2, 4) | rng(20, 31);
        mask[2] = rng(5, 7);
        mask[3] = rng(0, 5) | rng(10, 15);
        mask[4] = 32'hFFFF_FFFF;
        mask[5] = 32'h0000_0000;
        mask[6] = 32'hFFFF_FFFF;
        mask[7] = rng(28, 31);
        l0 = loads;
        start_cal();
        total++; if (bus.CAL_BUSY !== 1'b1 || bus.CAL_DONE !== 1'b0) begin bad++; $display("FAIL mixed_busy busy=%b done=%b want busy=1 done=0", bus.CAL_BUSY, bus.CAL_DONE); end
        wait_done(100, n);
        total++; if (n !== CAL_CYC) begin bad++; $display("FAIL mixed_cycles got=%0d want=%0d", n, CAL_CYC); end
        total++; if (bus.DLY_TAP_OUT !== {5'd30, 5'd16, 5'd12, 5'd16, 5'd3, 5'd12, 5'd26, 5'd12}) begin bad++; $display("FAIL mixed_taps got=%h want=%h", bus.DLY_TAP_OUT, {5'd30, 5'd16, 5'd12, 5'd16, 5'd3, 5'd12, 5'd26, 5'd12}); end
        total++; if (bus.CAL_FAIL !== 8'h24) begin bad++; $display("FAIL mixed_fail got=%h want=24", bus.CAL_FAIL); end
        total++; if ({bus.DATA_VALID, bus.CAL_BUSY, bus.CAL_DONE} !== 3'b001) begin bad++; $display("FAIL mixed_status got=%b want=001", {bus.DATA_VALID, bus.CAL_BUSY, bus.CAL_DONE}); end
        total++; if (loads - l0 !== LOADS_PER_CAL) begin bad++; $display("FAIL mixed_load_pulses got=%0d want=%0d", loads - l0, LOADS_PER_CAL); end
    endtask

    task automatic test_all_pass();
        int n;
        raw = 1'b0;
        for (int k = 0; k < CH; k++) mask[k] = 32'hFFFF_FFFF;
        start_cal();
        total++; if (bus.CAL_FAIL !== 8'h00 || bus.CAL_DONE !== 1'b0) begin bad++; $display("FAIL restart_clear fail=%h done=%b want fail=00 done=0", bus.CAL_FAIL, bus.CAL_DONE); end
        total++; if (bus.CAL_BUSY !== 1'b1 || bus.DATA_VALID !== 1'b0) begin bad++; $display("FAIL restart_busy busy=%b valid=%b want busy=1 valid=0", bus.CAL_BUSY, bus.DATA_VALID); end
        wait_done(-1, n);
        total++; if (n !== CAL_CYC) begin bad++; $display("FAIL allpass_cycles got=%0d want=%0d", n, CAL_CYC); end
        total++; if (bus.DLY_TAP_OUT !== {CH{5'd16}}) begin bad++; $display("FAIL allpass_taps got=%h want=%h", bus.DLY_TAP_OUT, {CH{5'd16}}); end
        total++; if (bus.CAL_FAIL !== 8'h00) begin bad++; $display("FAIL allpass_fail got=%h want=00", bus.CAL_FAIL); end
        total++; if ({bus.DATA_VALID, bus.CAL_BUSY, bus.CAL_DONE} !== 3'b101) begin bad++; $display("FAIL allpass_status got=%b want=101", {bus.DATA_VALID, bus.CAL_BUSY, bus.CAL_DONE}); end
    endtask

    task automatic test_reset_mid();
        int l0;
        raw = 1'b0;
        for (int k = 0; k < CH; k++) mask[k] = 32'hFFFF_FFFF;
        start_cal();
        repeat (520) @(posedge clk);
        #1;
        total++; if (bus.CAL_BUSY !== 1'b1 || bus.DLY_TAP_OUT[2*TW +: TW] !== 5'd0) begin bad++; $display("FAIL mid_progress busy=%b ch2tap=%0d want busy=1 ch2tap=0", bus.CAL_BUSY, bus.DLY_TAP_OUT[2*TW +: TW]); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.DLY_TAP_OUT !== {CH{5'd12}}) begin bad++; $display("FAIL mid_rst_taps got=%h want=%h", bus.DLY_TAP_OUT, {CH{5'd12}}); end
        total++; if (bus.DLY_LOAD !== 8'h00 || bus.CAL_FAIL !== 8'h00) begin bad++; $display("FAIL mid_rst_load_fail load=%h fail=%h want 00 00", bus.DLY_LOAD, bus.CAL_FAIL); end
        total++; if (bus.CH_DATA_OUT !== '0) begin bad++; $display("FAIL mid_rst_data got=%h want=0", bus.CH_DATA_OUT); end
        total++; if ({bus.DATA_VALID, bus.CAL_BUSY, bus.CAL_DONE} !== 3'b000) begin bad++; $display("FAIL mid_rst_status got=%b want=000", {bus.DATA_VALID, bus.CAL_BUSY, bus.CAL_DONE}); end
        @(posedge clk);
        #1;
        total++; if (bus.CAL_BUSY !== 1'b0 || bus.DLY_TAP_OUT !== {CH{5'd12}}) begin bad++; $display("FAIL mid_rst_hold busy=%b taps=%h want busy=0 taps=%h", bus.CAL_BUSY, bus.DLY_TAP_OUT, {CH{5'd12}}); end
        rst_n = 1'b1;
        l0 = loads;
        repeat (40) @(posedge clk);
        #1;
        total++; if (loads - l0 !== 0) begin bad++; $display("FAIL release_no_load got=%0d want=0", loads - l0); end
        total++; if (bus.CAL_BUSY !== 1'b0 || bus.CAL_DONE !== 1'b0) begin bad++; $display("FAIL release_idle busy=%b done=%b want 0 0", bus.CAL_BUSY, bus.CAL_DONE); end
        total++; if (bus.DLY_TAP_OUT !== {CH{5'd12}}) begin bad++; $display("FAIL release_taps got=%h want=%h", bus.DLY_TAP_OUT, {CH{5'd12}}); end
    endtask

    initial begin
        bus.CAL_START = 1'b0;
        for (int k = 0; k < CH; k++) mask[k] = '0;
        test_reset();
        test_data_pipe();
        test_cal_mixed();
        test_all_pass();
        test_data_pipe();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_nch_tap_cal.md
ADC_NCH_TAP_CAL -- requirements
Module: adc_nch_tap_cal

Interface
REQ-001 Parameter CH_NUM, default 4, number of ADC channels calibrated and forwarded.
REQ-002 Parameter DATA_W, default 16, width of one deserialized channel word.
REQ-003 Parameter TAP_W, default 5, input-delay tap width (taps 0..2^TAP_W-1).
REQ-004 Parameter TRAIN_PAT, default 16'hA5C3, ADC training word expected during calibration.
REQ-005 Parameter SETTLE_CYC, default 16, wait cycles after each tap load; CHECK_CYC, default 64, compare cycles per tap.
REQ-006 Parameter MIN_WIN, default 4, minimum passing-window length; DEF_TAP, default 12, fallback tap.
REQ-007 ADCLK_100M  in  1  sole clock (deserializer divided clock); all logic rising-edge.
REQ-008 IO_RST_N  in  1  reset, asynchronous assert, active-low.
REQ-009 CAL_START  in  1  single-cycle calibration request.
REQ-010 CH_DATA_IN  in  CH_NUM*DATA_W  parallel words, channel k at bits [k*DATA_W +: DATA_W].
REQ-011 DLY_TAP_OUT  out  CH_NUM*TAP_W  per-channel tap value, same packing.
REQ-012 DLY_LOAD  out  CH_NUM  per-channel one-cycle tap-load strobe.
REQ-013 CH_DATA_OUT  out  CH_NUM*DATA_W  registered copy of CH_DATA_IN.
REQ-014 DATA_VALID  out  1  high when calibration complete and no channel failed.
REQ-015 CAL_BUSY  out  1  high while FSM not in IDLE/DONE; CAL_DONE  out  1  level, set at completion.
REQ-016 CAL_FAIL  out  CH_NUM  per-channel sticky flag, window shorter than MIN_WIN.

Function
REQ-017 CH_DATA_OUT shall equal CH_DATA_IN delayed exactly one cycle, regardless of calibration state.
REQ-018 FSM states: IDLE, LOAD, SETTLE, CHECK, EVAL, CENTER, NEXT_CH, DONE.
REQ-019 IDLE/DONE + CAL_START -> LOAD with channel index 0, tap 0, tracker cleared, CAL_DONE and CAL_FAIL cleared.
REQ-020 CAL_START while CAL_BUSY shall be ignored.
REQ-021 LOAD: drive current tap on active channel's DLY_TAP_OUT, pulse its DLY_LOAD one cycle, -> SETTLE.
REQ-022 SETTLE: count SETTLE_CYC cycles, -> CHECK.
REQ-023 CHECK: for CHECK_CYC cycles compare active channel's CH_DATA_IN to TRAIN_PAT; tap passes only if every cycle matches; -> EVAL.
REQ-024 EVAL: update tracker with pass/fail; if tap = max -> CENTER, else tap+1 -> LOAD.
REQ-025 Tracker keeps current run start/length and best run start/length; a run still open at max tap shall be closed and considered; on equal length the earlier run is kept.
REQ-026 CENTER: if best length >= MIN_WIN, final tap = best_start + floor(best_len/2); else final tap = DEF_TAP and CAL_FAIL[ch] set; drive final tap, pulse DLY_LOAD[ch]; -> NEXT_CH.
REQ-027 NEXT_CH: if ch = CH_NUM-1 -> DONE, else ch+1, tap 0, tracker cleared -> LOAD.
REQ-028 DONE: CAL_DONE=1, CAL_BUSY=0; DATA_VALID = CAL_DONE and not |CAL_FAIL.
REQ-029 Taps of non-active channels shall hold their last value; arithmetic for center computed at TAP_W+1 bits, result always <= max tap.
REQ-030 Per-channel cycle count = 2^TAP_W*(1+SETTLE_CYC+CHECK_CYC+1)+2.

Reset
REQ-031 IO_RST_N low: state IDLE, all DLY_TAP_OUT = DEF_TAP, DLY_LOAD=0, CH_DATA_OUT=0, DATA_VALID/CAL_BUSY/CAL_DONE=0, CAL_FAIL=0, counters and tracker 0.
REQ-032 Reset mid-calibration shall abort immediately; no DLY_LOAD pulse on release; new CAL_START required.

Structure
REQ-033 Package adc_cal_pkg holds FSM state enum and default constants (TRAIN_PAT, DEF_TAP, MIN_WIN).
REQ-034 Sub-module adc_win_tracker holds the run/best-window logic (clear, update with pass, close, best_start, best_len).

Verification
REQ-035 Pattern correct only for taps 8..15 on ch0 -> DLY_TAP_OUT ch0 = 12, CAL_FAIL[0]=0.
REQ-036 Pass taps 2..4 and 20..31 -> tap 26 (open run at max closed, longest wins).
REQ-037 Pass taps 5..7 only (len 3 < MIN_WIN) -> tap DEF_TAP=12, CAL_FAIL bit set, DATA_VALID=0 after DONE.
REQ-038 Equal runs 0..5 and 10..15 -> tap 3 (earlier kept); second CAL_START while busy -> no restart.
REQ-039 IO_RST_N low during CHECK of channel 2 -> all outputs reset values next edge, FSM IDLE, no DLY_LOAD after release.
REQ-040 CH_NUM=8, all taps pass -> every tap 16, CAL_DONE after 8*(32*82+2) cycles, CH_DATA_OUT lags input one cycle.
